// File: rtl/keypad_emulator_if.sv
// Key command channel: a key code plus its closed-hold duration, valid/ready handshake.
interface keypad_emulator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Keypad matrix emulator: replays queued key presses, with contact bounce, onto a
// scanned 4x4 matrix by echoing the key's row drive onto the key's column sense.
module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  keypad_emulator_if.slave cmd,
  input  logic [3:0]       rows,
  output logic [3:0]       cols,
  output logic             busy,
  output logic [7:0]       press_count
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BC_LAST = 16'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [19:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [19:0] head;
  logic        full, empty, push, pop, hold_entry, closed;
  logic [3:0]  key_p0;
  logic [15:0] hold_p0;
  logic [3:0]  cols_p0;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign push          = cmd.cmd_valid && !full;
  assign cmd.cmd_ready = !full;
  assign busy          = (state != IDLE) || !empty;
  assign head          = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cmd.cmd_key, cmd.cmd_hold};
  end

  // A zero hold is stored as one so HOLD always lasts at least a cycle.
  always_ff @(posedge CLOCK_50) begin
    if (pop) begin
      key_p0  <= head[19:16];
      hold_p0 <= (head[15:0] == 16'd0) ? 16'd1 : head[15:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 16'd1;
    pop        = 1'b0;
    hold_entry = 1'b0;
    closed     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (!empty) begin
          pop = 1'b1;
          if (BOUNCE_CYCLES == 0) begin
            state_nxt  = HOLD;
            hold_entry = 1'b1;
          end else begin
            state_nxt = BOUNCE_IN;
          end
        end
      end
      BOUNCE_IN: begin
        closed = ~cnt[0];
        if (cnt == BC_LAST) begin
          state_nxt  = HOLD;
          cnt_nxt    = 16'd0;
          hold_entry = 1'b1;
        end
      end
      HOLD: begin
        closed = 1'b1;
        if (cnt == hold_p0 - 16'd1) begin
          cnt_nxt   = 16'd0;
          state_nxt = (BOUNCE_CYCLES == 0) ? IDLE : BOUNCE_OUT;
        end
      end
      BOUNCE_OUT: begin
        closed = ~cnt[0];
        if (cnt == BC_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Only the key's own row reaches its column; every other column stays released.
    cols_p0 = 4'hF;
    if (closed) cols_p0[key_p0[1:0]] = rows[key_p0[3:2]];
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      press_count <= 8'd0;
      cols        <= 4'hF;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cols  <= cols_p0;
      if (push)       wr_ptr      <= wr_ptr + 1'b1;
      if (pop)        rd_ptr      <= rd_ptr + 1'b1;
      if (hold_entry) press_count <= press_count + 8'd1;
    end
  end
endmodule
